// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared opcode encoding and default widths for the instruction register
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int OPERAND_W_DEF = 32;
  localparam int DEPTH_DEF     = 32;

endpackage

// File: rtl/instr_alu.sv
// rtl/instr_alu.sv - combinational signed ALU producing a sign-extended result and a divide-by-zero flag
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OPERAND_W = OPERAND_W_DEF,
  parameter int RESULT_W  = 2 * OPERAND_W
) (
  input  opcode_t                      opcode,
  input  logic signed [OPERAND_W-1:0]  operand_a,
  input  logic signed [OPERAND_W-1:0]  operand_b,
  output logic signed [RESULT_W-1:0]   result,
  output logic                         div_zero
);

  logic signed [RESULT_W-1:0] a_ext;
  logic signed [RESULT_W-1:0] b_ext;
  logic signed [RESULT_W-1:0] b_safe;
  logic                       b_zero;

  // Working at RESULT_W keeps MIN/-1 and the full product exact.
  assign a_ext  = {{(RESULT_W-OPERAND_W){operand_a[OPERAND_W-1]}}, operand_a};
  assign b_ext  = {{(RESULT_W-OPERAND_W){operand_b[OPERAND_W-1]}}, operand_b};
  assign b_zero = (operand_b == '0);
  assign b_safe = b_zero ? {{(RESULT_W-1){1'b0}}, 1'b1} : b_ext;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (b_zero) div_zero = 1'b1;
        else        result   = a_ext / b_safe;
      end
      MOD: begin
        if (b_zero) div_zero = 1'b1;
        else        result   = a_ext % b_safe;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - instruction register with one-stage compute pipeline, forwarding read port
// and occupancy count
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int OPERAND_W = OPERAND_W_DEF,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RESULT_W  = 2 * OPERAND_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_en,
  input  logic [ADDR_W-1:0]              write_pointer,
  input  opcode_t                        opcode,
  input  logic signed [OPERAND_W-1:0]    operand_a,
  input  logic signed [OPERAND_W-1:0]    operand_b,
  input  logic                           read_en,
  input  logic [ADDR_W-1:0]              read_pointer,
  output logic                           rd_valid,
  output logic                           rd_entry_valid,
  output opcode_t                        rd_opcode,
  output logic signed [OPERAND_W-1:0]    rd_operand_a,
  output logic signed [OPERAND_W-1:0]    rd_operand_b,
  output logic signed [RESULT_W-1:0]     rd_result,
  output logic                           rd_div_zero,
  output logic                           wr_pending,
  output logic [$clog2(DEPTH+1)-1:0]     valid_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    opcode_t                     opcode;
    logic signed [OPERAND_W-1:0] operand_a;
    logic signed [OPERAND_W-1:0] operand_b;
    logic signed [RESULT_W-1:0]  result;
    logic                        div_zero;
  } entry_t;

  entry_t                      mem [DEPTH];
  logic [DEPTH-1:0]            mem_valid;

  logic                        s_valid;
  logic [ADDR_W-1:0]           s_addr;
  opcode_t                     s_opcode;
  logic signed [OPERAND_W-1:0] s_a;
  logic signed [OPERAND_W-1:0] s_b;

  logic signed [RESULT_W-1:0]  alu_result;
  logic                        alu_div_zero;
  entry_t                      s_entry;

  entry_t                      rd_sel;
  logic                        rd_sel_valid;
  logic                        fwd_hit;

  instr_alu #(
    .OPERAND_W (OPERAND_W),
    .RESULT_W  (RESULT_W)
  ) u_alu (
    .opcode    (s_opcode),
    .operand_a (s_a),
    .operand_b (s_b),
    .result    (alu_result),
    .div_zero  (alu_div_zero)
  );

  always_comb begin
    s_entry           = '0;
    s_entry.opcode    = s_opcode;
    s_entry.operand_a = s_a;
    s_entry.operand_b = s_b;
    s_entry.result    = alu_result;
    s_entry.div_zero  = alu_div_zero;
  end

  // Stage S: captures a load, commits it one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_valid  <= 1'b0;
      s_addr   <= '0;
      s_opcode <= ZERO;
      s_a      <= '0;
      s_b      <= '0;
    end else begin
      s_valid <= load_en;
      if (load_en) begin
        s_addr   <= write_pointer;
        s_opcode <= opcode;
        s_a      <= operand_a;
        s_b      <= operand_b;
      end
    end
  end

  assign wr_pending = s_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_valid   <= '0;
      valid_count <= '0;
    end else if (s_valid) begin
      mem[s_addr]       <= s_entry;
      mem_valid[s_addr] <= 1'b1;
      if (!mem_valid[s_addr]) valid_count <= valid_count + CNT_W'(1);
    end
  end

  // The in-flight write in S is newer than the array, so it wins on a match.
  assign fwd_hit = s_valid && (s_addr == read_pointer);

  always_comb begin
    rd_sel       = mem[read_pointer];
    rd_sel_valid = mem_valid[read_pointer];
    if (fwd_hit) begin
      rd_sel       = s_entry;
      rd_sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid       <= 1'b0;
      rd_entry_valid <= 1'b0;
      rd_opcode      <= ZERO;
      rd_operand_a   <= '0;
      rd_operand_b   <= '0;
      rd_result      <= '0;
      rd_div_zero    <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        rd_entry_valid <= rd_sel_valid;
        rd_opcode      <= rd_sel.opcode;
        rd_operand_a   <= rd_sel.operand_a;
        rd_operand_b   <= rd_sel.operand_b;
        rd_result      <= rd_sel.result;
        rd_div_zero    <= rd_sel.div_zero;
      end
    end
  end

endmodule
